battle_engine: RTL and testbench
================================

BATTLE_ENGINE -- requirements
Module: battle_engine

Interface
REQ-001 Parameter TEAM_SIZE, default 5, max pets per team (1..7).
REQ-002 Parameter STAT_W, default 8, width of each attack/health stat.
REQ-003 Parameter MAX_ROUNDS, default 255, round cap before forced draw (1..255).
REQ-004 Ports, in this order:
  clk  in  1  rising-edge clock; one clock domain only.
  reset  in  1  asynchronous, active-high.
  actionFight  in  1  single-cycle battle request from control.
  playerAtk  in  TEAM_SIZE*STAT_W  player attacks; slot 0 in the LSBs is the front pet.
  playerHp  in  TEAM_SIZE*STAT_W  player health, same packing.
  playerCount  in  3  live player pets, 0..TEAM_SIZE.
  enemyAtk  in  TEAM_SIZE*STAT_W  enemy attacks, same packing.
  enemyHp  in  TEAM_SIZE*STAT_W  enemy health, same packing.
  enemyCount  in  3  live enemy pets, 0..TEAM_SIZE.
  busy  out  1  high in FIGHT and DONE.
  battleDone  out  1  single-cycle completion pulse.
  battleWin  out  1  result: player won.
  battleDraw  out  1  result: draw.

Function
REQ-005 FSM states are IDLE, FIGHT and DONE, and the FSM is in IDLE after reset.
REQ-006 In IDLE, actionFight=1 at a clock edge captures all stat and count inputs into internal team registers, zeroes pIdx, eIdx and the round counter, clears battleWin and battleDraw, and moves to FIGHT.
REQ-007 An empty team at capture (playerCount=0 or enemyCount=0) moves IDLE directly to DONE instead of FIGHT.
REQ-008 The FSM ignores actionFight in FIGHT and DONE, with no effect on state or registers.
REQ-009 Round: each FIGHT edge executes exactly one simultaneous clash between player slot pIdx and enemy slot eIdx.
REQ-010 Clash damage is saturating: each new hp = hp - opponentAtk, floored at 0, at STAT_W bits with no wrap.
REQ-011 A pet whose new hp is 0 faints, and its team index increments by 1 on that edge; both indices increment together when both pets faint.
REQ-012 The round counter increments by 1 on every FIGHT edge.
REQ-013 The edge that makes pIdx reach playerCount, makes eIdx reach enemyCount, or makes the round counter reach MAX_ROUNDS also moves the FSM to DONE.
REQ-014 Result decision, applied when DONE is entered:
  - Win: enemy exhausted and player not exhausted.
  - Draw: both teams exhausted, both counts 0 at capture, or round cap hit with both teams alive.
  - Loss: all other cases.
REQ-015 battleWin and battleDraw are registered on DONE entry, are mutually exclusive, and hold until the next accepted actionFight.
REQ-016 battleDone=1 for exactly the one cycle spent in DONE, after which DONE moves to IDLE unconditionally.
REQ-017 Latency: a battle of N rounds asserts battleDone N+1 cycles after the actionFight capture edge, and an empty-team battle asserts it 1 cycle after.
REQ-018 Input values presented while busy have no effect, since the battle uses only captured copies.

Reset
REQ-019 Reset forces IDLE and clears battleDone, battleWin, battleDraw, busy, pIdx, eIdx, the round counter and all team registers to 0.
REQ-020 Reset asserted mid-battle abandons the battle, and no battleDone is issued for it.

Configuration
REQ-021 With macro BATTLE_ROUNDS_OUT_EN defined, the block adds an output port roundCount (8 bits) after battleDraw.
REQ-022 With BATTLE_ROUNDS_OUT_EN defined, roundCount equals the round counter and holds its final value until the next capture.
REQ-023 With BATTLE_ROUNDS_OUT_EN undefined, the roundCount port and its logic are absent, and all other behaviour is identical.

Structure
REQ-024 Shared package auto_pets_pkg holds battle_state_t (IDLE/FIGHT/DONE) and the default constants TEAM_SIZE, STAT_W and MAX_ROUNDS.
REQ-025 One combinational sub-module, pet_clash, computes both saturated hp results and both faint flags for a single clash.

Verification
REQ-026 Single-pet draw: 1v1 with player atk 3/hp 3 and enemy atk 3/hp 3 -> battleDone 2 cycles after capture, battleDraw=1, battleWin=0.
REQ-027 Two-pet win: player {atk5/hp10, atk2/hp2} vs enemy {atk4/hp5, atk1/hp4} -> rounds: enemy0 faints; then enemy1 hp 4->0 while player0 hp 6->5; battleWin=1 after 2 rounds.
REQ-028 Empty teams:
  - playerCount=0, enemyCount=2 -> battleDone 1 cycle after capture, battleWin=0, battleDraw=0.
  - both counts 0 -> battleDraw=1.
REQ-029 Stalemate: both front pets atk 0, MAX_ROUNDS=4 -> battleDone 5 cycles after capture with battleDraw=1, plus roundCount=4 when BATTLE_ROUNDS_OUT_EN is defined.
REQ-030 actionFight pulsed while busy -> no restart; pulse-count check shows exactly one battleDone per accepted request.
REQ-031 Reset asserted in the 2nd FIGHT cycle -> outputs 0 immediately, IDLE; a following actionFight runs a full battle normally.

Source files
------------

// File: rtl/auto_pets_pkg.sv
// auto_pets_pkg: shared battle FSM state type and default team/stat/round constants.
package auto_pets_pkg;
  typedef enum logic [1:0] {IDLE, FIGHT, DONE} battle_state_t;
  localparam int TEAM_SIZE  = 5;
  localparam int STAT_W     = 8;
  localparam int MAX_ROUNDS = 255;
endpackage

// File: rtl/pet_clash.sv
// pet_clash: one simultaneous clash with saturating damage and faint detection.
module pet_clash #(
  parameter int STAT_W = auto_pets_pkg::STAT_W
) (
  input  logic [STAT_W-1:0] p_atk,
  input  logic [STAT_W-1:0] p_hp,
  input  logic [STAT_W-1:0] e_atk,
  input  logic [STAT_W-1:0] e_hp,
  output logic [STAT_W-1:0] p_hp_n,
  output logic [STAT_W-1:0] e_hp_n,
  output logic              p_faint,
  output logic              e_faint
);
  assign p_hp_n  = p_hp > e_atk ? p_hp - e_atk : '0;
  assign e_hp_n  = e_hp > p_atk ? e_hp - p_atk : '0;
  assign p_faint = p_hp_n == '0;
  assign e_faint = e_hp_n == '0;
endmodule

// File: rtl/battle_engine.sv
// battle_engine: captures two teams and fights them front-to-back, one clash per cycle.
// Define BATTLE_ROUNDS_OUT_EN to expose the round counter on roundCount.
module battle_engine #(
  parameter int TEAM_SIZE  = auto_pets_pkg::TEAM_SIZE,
  parameter int STAT_W     = auto_pets_pkg::STAT_W,
  parameter int MAX_ROUNDS = auto_pets_pkg::MAX_ROUNDS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        actionFight,
  input  logic [TEAM_SIZE*STAT_W-1:0] playerAtk,
  input  logic [TEAM_SIZE*STAT_W-1:0] playerHp,
  input  logic [2:0]                  playerCount,
  input  logic [TEAM_SIZE*STAT_W-1:0] enemyAtk,
  input  logic [TEAM_SIZE*STAT_W-1:0] enemyHp,
  input  logic [2:0]                  enemyCount,
  output logic                        busy,
  output logic                        battleDone,
  output logic                        battleWin,
  output logic                        battleDraw
`ifdef BATTLE_ROUNDS_OUT_EN
  ,
  output logic [7:0]                  roundCount
`endif
);
  import auto_pets_pkg::*;
  battle_state_t state;
  logic [STAT_W-1:0] p_atk [TEAM_SIZE];
  logic [STAT_W-1:0] p_hp  [TEAM_SIZE];
  logic [STAT_W-1:0] e_atk [TEAM_SIZE];
  logic [STAT_W-1:0] e_hp  [TEAM_SIZE];
  logic [2:0] p_cnt, e_cnt, p_idx, e_idx, np, ne, pc_in, ec_in;
  logic [7:0] rounds, nr;
  logic [STAT_W-1:0] p_hp_n, e_hp_n;
  logic p_faint, e_faint, p_exh, e_exh, cap;

  pet_clash #(.STAT_W(STAT_W)) u_clash (
    .p_atk(p_atk[p_idx]), .p_hp(p_hp[p_idx]),
    .e_atk(e_atk[e_idx]), .e_hp(e_hp[e_idx]),
    .p_hp_n(p_hp_n), .e_hp_n(e_hp_n),
    .p_faint(p_faint), .e_faint(e_faint)
  );

  // counts beyond the team size are clamped so indices never leave the arrays
  always_comb begin
    pc_in = playerCount > 3'(TEAM_SIZE) ? 3'(TEAM_SIZE) : playerCount;
    ec_in = enemyCount > 3'(TEAM_SIZE) ? 3'(TEAM_SIZE) : enemyCount;
    np    = p_idx + 3'(p_faint);
    ne    = e_idx + 3'(e_faint);
    nr    = rounds + 8'd1;
    p_exh = np == p_cnt;
    e_exh = ne == e_cnt;
    cap   = nr == 8'(MAX_ROUNDS);
  end

  assign busy       = state != IDLE;
  assign battleDone = state == DONE;
`ifdef BATTLE_ROUNDS_OUT_EN
  assign roundCount = rounds;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      p_cnt      <= '0;
      e_cnt      <= '0;
      p_idx      <= '0;
      e_idx      <= '0;
      rounds     <= '0;
      battleWin  <= 1'b0;
      battleDraw <= 1'b0;
      for (int i = 0; i < TEAM_SIZE; i++) begin
        p_atk[i] <= '0;
        p_hp[i]  <= '0;
        e_atk[i] <= '0;
        e_hp[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: if (actionFight) begin
          for (int i = 0; i < TEAM_SIZE; i++) begin
            p_atk[i] <= playerAtk[i*STAT_W +: STAT_W];
            p_hp[i]  <= playerHp[i*STAT_W +: STAT_W];
            e_atk[i] <= enemyAtk[i*STAT_W +: STAT_W];
            e_hp[i]  <= enemyHp[i*STAT_W +: STAT_W];
          end
          p_cnt      <= pc_in;
          e_cnt      <= ec_in;
          p_idx      <= '0;
          e_idx      <= '0;
          rounds     <= '0;
          // an empty team resolves at capture with the same win/draw rule
          battleWin  <= pc_in != 3'd0 && ec_in == 3'd0;
          battleDraw <= pc_in == 3'd0 && ec_in == 3'd0;
          state      <= (pc_in == 3'd0 || ec_in == 3'd0) ? DONE : FIGHT;
        end
        FIGHT: begin
          p_hp[p_idx] <= p_hp_n;
          e_hp[e_idx] <= e_hp_n;
          p_idx       <= np;
          e_idx       <= ne;
          rounds      <= nr;
          if (p_exh || e_exh || cap) begin
            state      <= DONE;
            battleWin  <= e_exh && !p_exh;
            battleDraw <= (p_exh && e_exh) || (cap && !p_exh && !e_exh);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine: directed battles with hand-computed latency and result checks.
module tb_battle_engine;
  localparam int N = 40;
  logic clk = 1'b0;
  logic reset, af, af4;
  logic [N-1:0] pa, ph, ea, eh;
  logic [2:0] pc, ec;
  logic busy, done, win, draw, busy4, done4, win4, draw4;
`ifdef BATTLE_ROUNDS_OUT_EN
  logic [7:0] rc, rc4;
`endif
  int checks = 0;
  int failures = 0;
  int lat, n;

  always #5 clk = ~clk;

  battle_engine dut (
    .clk(clk), .reset(reset), .actionFight(af),
    .playerAtk(pa), .playerHp(ph), .playerCount(pc),
    .enemyAtk(ea), .enemyHp(eh), .enemyCount(ec),
    .busy(busy), .battleDone(done), .battleWin(win), .battleDraw(draw)
`ifdef BATTLE_ROUNDS_OUT_EN
    , .roundCount(rc)
`endif
  );

  battle_engine #(.MAX_ROUNDS(4)) dut4 (
    .clk(clk), .reset(reset), .actionFight(af4),
    .playerAtk(pa), .playerHp(ph), .playerCount(pc),
    .enemyAtk(ea), .enemyHp(eh), .enemyCount(ec),
    .busy(busy4), .battleDone(done4), .battleWin(win4), .battleDraw(draw4)
`ifdef BATTLE_ROUNDS_OUT_EN
    , .roundCount(rc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic team(input logic [N-1:0] a, h, b, g, input logic [2:0] c, d);
    pa = a; ph = h; ea = b; eh = g; pc = c; ec = d;
  endtask

  // latency counts negedges after the capture edge up to the one showing battleDone
  task automatic fight(input bit four, output int l);
    @(negedge clk);
    if (four) af4 = 1'b1; else af = 1'b1;
    @(posedge clk);
    #1 af = 1'b0; af4 = 1'b0;
    l = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (four ? done4 : done) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; af = 1'b0; af4 = 1'b0;
    team('0, '0, '0, '0, 3'd0, 3'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win", win, 0);
    chk("rst_draw", draw, 0);
    reset = 1'b0;

    team({32'd0, 8'd3}, {32'd0, 8'd3}, {32'd0, 8'd3}, {32'd0, 8'd3}, 3'd1, 3'd1);
    fight(1'b0, lat);
    chk("draw1_lat", lat, 2);
    chk("draw1_draw", draw, 1);
    chk("draw1_win", win, 0);

    team({24'd0, 8'd2, 8'd5}, {24'd0, 8'd2, 8'd10}, {24'd0, 8'd1, 8'd4}, {24'd0, 8'd4, 8'd5}, 3'd2, 3'd2);
    fight(1'b0, lat);
    chk("win2_lat", lat, 3);
    chk("win2_win", win, 1);
    chk("win2_draw", draw, 0);
`ifdef BATTLE_ROUNDS_OUT_EN
    chk("win2_rounds", rc, 2);
`endif
    repeat (3) @(negedge clk);
    chk("win2_hold", win, 1);
    chk("idle_busy", busy, 0);

    team({32'd0, 8'd1}, {32'd0, 8'd1}, {32'd0, 8'd5}, {32'd0, 8'd5}, 3'd1, 3'd1);
    fight(1'b0, lat);
    chk("loss_lat", lat, 2);
    chk("loss_win", win, 0);
    chk("loss_draw", draw, 0);

    team('0, '0, {24'd0, 8'd1, 8'd1}, {24'd0, 8'd1, 8'd1}, 3'd0, 3'd2);
    fight(1'b0, lat);
    chk("emptyp_lat", lat, 1);
    chk("emptyp_win", win, 0);
    chk("emptyp_draw", draw, 0);
    chk("emptyp_busy", busy, 1);

    team('0, '0, '0, '0, 3'd0, 3'd0);
    fight(1'b0, lat);
    chk("empty2_lat", lat, 1);
    chk("empty2_draw", draw, 1);
    chk("empty2_win", win, 0);

    team({32'd0, 8'd0}, {32'd0, 8'd5}, {32'd0, 8'd0}, {32'd0, 8'd5}, 3'd1, 3'd1);
    fight(1'b1, lat);
    chk("stale_lat", lat, 5);
    chk("stale_draw", draw4, 1);
    chk("stale_win", win4, 0);
`ifdef BATTLE_ROUNDS_OUT_EN
    chk("stale_rounds", rc4, 4);
`endif

    team({24'd0, 8'd2, 8'd5}, {24'd0, 8'd2, 8'd10}, {24'd0, 8'd1, 8'd4}, {24'd0, 8'd4, 8'd5}, 3'd2, 3'd2);
    @(negedge clk);
    af = 1'b1;
    @(posedge clk);
    #1 team('1, '0, '0, '1, 3'd0, 3'd5);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n++;
      af = busy;
    end
    af = 1'b0;
    chk("busy_pulses", n, 1);
    chk("busy_win", win, 1);
    chk("busy_draw", draw, 0);

    team({32'd0, 8'd1}, {32'd0, 8'd5}, {32'd0, 8'd1}, {32'd0, 8'd5}, 3'd1, 3'd1);
    @(negedge clk);
    af = 1'b1;
    @(posedge clk);
    #1 af = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_win", win, 0);
    chk("midrst_draw", draw, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("midrst_nodone", n, 0);
    fight(1'b0, lat);
    chk("after_lat", lat, 6);
    chk("after_draw", draw, 1);
    chk("after_win", win, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
